// File: rtl/a8_bus_master.sv
// Atari 8-bit bus initiator: generates the phase-2 clock from clk200 and runs single-byte
// read/write cycles requested through a one-entry command holding register.
module a8_bus_master #(
  parameter int unsigned HALF_PERIOD = 58,        // clk200 cycles per a8_clk phase (4..255)
  parameter int unsigned DATA_DELAY  = 20,        // write-data drive delay after a8_clk rise
  parameter logic [15:0] IDLE_ADDR   = 16'h0000   // address shown during idle bus cycles
) (
  input  logic        clk200,
  input  logic        a8_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw_n,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        resp_valid,
  output logic        resp_rw_n,
  output logic [7:0]  resp_rdata,
  output logic        a8_clk,
  output logic [15:0] a8_addr,
  output logic        a8_rw_n,
  output logic [7:0]  a8_data_out,
  output logic        a8_data_oe,
  input  logic [7:0]  a8_data_in
);

  logic [7:0]  phase_q, phase_d;
  logic        clk_q, clk_d;
  logic        hold_full_q, hold_full_d;
  logic        hold_rw_n_q, hold_rw_n_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_wdata_q, hold_wdata_d;
  logic        act_valid_q, act_valid_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_n_q, rw_n_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_rw_n_q, resp_rw_n_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;

  logic wrap, fall, accept;

  // Next-state: phase counter/clock, command holding, launch/complete at the a8_clk fall.
  always_comb begin
    wrap   = (phase_q == 8'(HALF_PERIOD - 1));
    fall   = wrap & clk_q;
    accept = cmd_valid & ~hold_full_q;

    phase_d      = wrap ? 8'd0 : phase_q + 8'd1;
    clk_d        = wrap ? ~clk_q : clk_q;
    hold_full_d  = hold_full_q;
    hold_rw_n_d  = hold_rw_n_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    act_valid_d  = act_valid_q;
    addr_d       = addr_q;
    rw_n_d       = rw_n_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    resp_valid_d = 1'b0;
    resp_rw_n_d  = resp_rw_n_q;
    resp_rdata_d = resp_rdata_q;

    // The holding register empties at a fall; a command accepted on that same edge
    // (only possible when it was already empty) stays held for the following fall.
    if (fall && hold_full_q) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_rw_n_d  = cmd_rw_n;
      hold_addr_d  = cmd_addr;
      hold_wdata_d = cmd_wdata;
    end

    if (fall) begin
      // Complete the cycle that is ending.
      if (act_valid_q) begin
        resp_valid_d = 1'b1;
        resp_rw_n_d  = rw_n_q;
        if (rw_n_q) resp_rdata_d = a8_data_in;
      end
      oe_d = 1'b0;
      // Launch the next cycle (or an idle one) on the same edge.
      if (hold_full_q) begin
        act_valid_d = 1'b1;
        addr_d      = hold_addr_q;
        rw_n_d      = hold_rw_n_q;
        dout_d      = hold_wdata_q;
      end else begin
        act_valid_d = 1'b0;
        addr_d      = IDLE_ADDR;
        rw_n_d      = 1'b1;
      end
    end else if (clk_d && (phase_d == 8'(DATA_DELAY)) && act_valid_q && !rw_n_q) begin
      // Comparing next-state values lets DATA_DELAY=0 assert on the rise edge itself.
      oe_d = 1'b1;
    end
  end

  // State registers with asynchronous reset; reset drops any held or in-flight command.
  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      phase_q      <= 8'd0;
      clk_q        <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_rw_n_q  <= 1'b1;
      hold_addr_q  <= 16'h0000;
      hold_wdata_q <= 8'h00;
      act_valid_q  <= 1'b0;
      addr_q       <= IDLE_ADDR;
      rw_n_q       <= 1'b1;
      dout_q       <= 8'h00;
      oe_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rw_n_q  <= 1'b1;
      resp_rdata_q <= 8'h00;
    end else begin
      phase_q      <= phase_d;
      clk_q        <= clk_d;
      hold_full_q  <= hold_full_d;
      hold_rw_n_q  <= hold_rw_n_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      act_valid_q  <= act_valid_d;
      addr_q       <= addr_d;
      rw_n_q       <= rw_n_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      resp_valid_q <= resp_valid_d;
      resp_rw_n_q  <= resp_rw_n_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign cmd_ready   = ~hold_full_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rw_n   = resp_rw_n_q;
  assign resp_rdata  = resp_rdata_q;
  assign a8_clk      = clk_q;
  assign a8_addr     = addr_q;
  assign a8_rw_n     = rw_n_q;
  assign a8_data_out = dout_q;
  assign a8_data_oe  = oe_q;

endmodule
